// File: rtl/bsg_counter_set_down_sched_pkg.sv
// Shared types for the scheduled set-down counter: FSM state encoding and
// the width of the owner index derived from the number of requesters.
package bsg_counter_set_down_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int owner_width(input int els);
    return (els <= 2) ? 1 : $clog2(els);
  endfunction

endpackage

// File: rtl/bsg_counter_set_down_sched_rr.sv
// Round-robin picker: combinational search from ptr with wrap-around.
// Only the search pointer is stored.
module bsg_counter_set_down_sched_rr
  import bsg_counter_set_down_sched_pkg::*;
#(
  parameter  int els_p = 4,
  localparam int ow_lp = owner_width(els_p)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [els_p-1:0] req_i,
  input  logic             yumi_i,
  output logic [els_p-1:0] grant_o,
  output logic [ow_lp-1:0] idx_o,
  output logic             v_o
);

  logic [ow_lp-1:0] ptr_q, ptr_d;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    for (int k = 0; k < els_p; k++) begin
      int j;
      j = (int'(ptr_q) + k) % els_p;
      if (!v_o && req_i[j]) begin
        v_o        = 1'b1;
        idx_o      = ow_lp'(j);
        grant_o[j] = 1'b1;
      end
    end
  end

  // Next search starts just past the requester that was served.
  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i && v_o) begin
      ptr_d = (int'(idx_o) == els_p - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bsg_counter_set_down_sched.sv
// Shared down-counter granted round-robin to one requester at a time;
// pulses done_o to the owner when its delay expires, kill_i aborts silently.
module bsg_counter_set_down_sched
  import bsg_counter_set_down_sched_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [els_p-1:0]              v_i,
  input  logic [els_p*width_p-1:0]      delay_i,
  output logic [els_p-1:0]              yumi_o,
  output logic [els_p-1:0]              done_o,
  input  logic                          kill_i,
  output logic                          busy_o,
  output logic [width_p-1:0]            count_o,
  output logic [owner_width(els_p)-1:0] owner_o
);

  localparam int ow_lp = owner_width(els_p);

  state_e             state_q, state_d;
  logic [width_p-1:0] count_q, count_d;
  logic [ow_lp-1:0]   owner_q, owner_d;

  logic [els_p-1:0]   rr_grant;
  logic [ow_lp-1:0]   rr_idx;
  logic               rr_v;
  logic               grant;

  // Gating with reset_i keeps yumi_o quiet while reset is held.
  assign grant = (state_q == IDLE) && rr_v && !reset_i;

  bsg_counter_set_down_sched_rr #(
    .els_p(els_p)
  ) u_rr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .req_i  (v_i),
    .yumi_i (grant),
    .grant_o(rr_grant),
    .idx_o  (rr_idx),
    .v_o    (rr_v)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    owner_d = owner_q;
    yumi_o  = '0;
    done_o  = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          yumi_o  = rr_grant;
          count_d = delay_i[rr_idx*width_p +: width_p];
          owner_d = rr_idx;
          state_d = RUN;
        end
      end
      RUN: begin
        if (kill_i) begin
          count_d = '0;
          state_d = IDLE;
        end else if (count_q == '0) begin
          done_o[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      owner_q <= owner_d;
    end
  end

  assign busy_o  = (state_q == RUN);
  assign count_o = count_q;
  assign owner_o = owner_q;

endmodule

// File: doc/bsg_counter_set_down_sched.md
BSG_COUNTER_SET_DOWN_SCHED -- requirements
Module: bsg_counter_set_down_sched

Interface
REQ-001 The block SHALL have parameter els_p, default 4, giving the number of requesters (2..16).
REQ-002 The block SHALL have parameter width_p, default 32, giving the delay and counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset_i  input  1  asynchronous active-high reset.
REQ-006 Port v_i  input  els_p  per-requester delay request valid.
REQ-007 Port delay_i  input  els_p*width_p  per-requester delay; slice i is bits [i*width_p +: width_p].
REQ-008 Port yumi_o  output  els_p  one-hot, single-cycle acceptance of request i.
REQ-009 Port done_o  output  els_p  one-hot, single-cycle completion pulse to the owning requester.
REQ-010 Port kill_i  input  1  aborts the running delay.
REQ-011 Port busy_o  output  1  high while a delay is running.
REQ-012 Port count_o  output  width_p  current down-counter value.
REQ-013 Port owner_o  output  max(1,log2(els_p))  index of the current owner.

Function
REQ-014 The FSM SHALL have two states: IDLE and RUN.
REQ-015 In IDLE with any v_i high, the block SHALL grant the requester selected by REQ-016 and assert yumi_o[winner] combinationally in that cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at ptr and wraps; after a grant to i, ptr becomes (i+1) mod els_p.
REQ-017 On a grant in cycle T, count SHALL load delay_i[winner], owner SHALL load winner, and the state SHALL be RUN from T+1.
REQ-018 In RUN with count != 0 and kill_i low, count SHALL decrement by 1 each cycle and SHALL never wrap below 0.
REQ-019 In RUN with count == 0, done_o[owner] SHALL be high for that cycle and the state SHALL return to IDLE, so done occurs in cycle T+1+D.
REQ-020 A delay of 0 SHALL produce done_o in cycle T+1.
REQ-021 In RUN with kill_i high, the state SHALL return to IDLE, count SHALL clear to 0, and no done_o SHALL be pulsed; kill_i SHALL be ignored in IDLE.
REQ-022 yumi_o SHALL stay all-zero in RUN; v_i and delay_i SHALL be held stable by the requester until yumi_o.
REQ-023 The earliest next grant after done or kill SHALL be the following cycle (one IDLE bubble).
REQ-024 busy_o SHALL equal (state == RUN).
REQ-025 count_o and owner_o SHALL hold their last values in IDLE, except that kill clears count.
REQ-026 done_o and yumi_o SHALL never be asserted in the same cycle.

Reset
REQ-027 Asserting reset_i at any time, including mid-RUN, SHALL immediately force the state to IDLE and set count, owner and ptr to 0.
REQ-028 While reset_i is high, yumi_o, done_o and busy_o SHALL be 0 and no done_o SHALL be issued for an aborted delay.

Structure
REQ-029 Package bsg_counter_set_down_sched_pkg SHALL hold the state enum (IDLE, RUN) and the owner-index width function.
REQ-030 The round-robin picker SHALL be one sub-module, bsg_counter_set_down_sched_rr, which is purely combinational apart from ptr, and is parameterised by els_p.

Verification
REQ-031 Reset, then v_i=0001 with delay 3 -> yumi_o=0001 at T, count_o 3,2,1,0 over T+1..T+4, and done_o=0001 at T+4.
REQ-032 v_i=1111 held with all delays 0 after reset -> grants issued in the order 0,1,2,3,0, one every 2 cycles.
REQ-033 Delay 0 on requester 2 -> done_o=0100 one cycle after yumi_o.
REQ-034 Delay 10 with kill_i at the 4th RUN cycle -> next cycle busy_o=0 and count_o=0, with no done_o.
REQ-035 Delay 0xFFFF_FFFF loaded, then reset_i pulsed mid-count asynchronously -> outputs go to 0 immediately and there is no later done_o.
REQ-036 v_i=0110 with ptr=3 -> requester 1 is granted first, then 2.
